// File: rtl/step_sequencer_if.sv
// Control and display signals of the step sequencer.
// The master drives enable, mode and the divided clock; the slave returns the display state.
interface step_sequencer_if;
  logic       i_ena;
  logic       i_slowClk;
  logic [1:0] i_mode;
  logic [7:0] o_leds;
  logic [6:0] o_seg;
  logic       o_stepPulse;

  modport master (
    output i_ena, i_slowClk, i_mode,
    input  o_leds, o_seg, o_stepPulse
  );

  modport slave (
    input  i_ena, i_slowClk, i_mode,
    output o_leds, o_seg, o_stepPulse
  );
endinterface

// File: rtl/step_sequencer.sv
// Samples the divided clock as data, turns each rising edge into a one-cycle step
// and advances an LED pattern (count / chase / bounce / hold) plus a 7-segment step digit.
module step_sequencer (
  input  logic             i_clkPin,
  input  logic             i_rstPin,
  step_sequencer_if.slave  bus
);
  localparam logic [0:0] DIR_LEFT    = 1'b0;
  localparam logic [0:0] DIR_RIGHT   = 1'b1;
  localparam logic [1:0] MODE_COUNT  = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  logic       s1_reg, s2_reg, prev_reg;
  logic [1:0] mode_reg, mode_next;
  logic [0:0] dir_reg, dir_next;
  logic [3:0] digit_reg, digit_next;
  logic [7:0] leds_reg, leds_next;
  logic [6:0] seg_reg, seg_next;
  logic       pulse_reg;
  logic       step, accept, leds_onehot;

  assign step        = s2_reg & ~prev_reg;
  assign accept      = step & bus.i_ena;
  assign leds_onehot = (leds_reg != 8'h00) && ((leds_reg & (leds_reg - 8'd1)) == 8'h00);

  always_comb begin
    mode_next  = mode_reg;
    dir_next   = dir_reg;
    digit_next = digit_reg;
    leds_next  = leds_reg;
    if (accept) begin
      if (bus.i_mode != mode_reg) begin
        // A mode change only loads the starting pattern; the digit does not move.
        mode_next = bus.i_mode;
        case (bus.i_mode)
          MODE_COUNT:  leds_next = 8'h00;
          MODE_CHASE:  leds_next = 8'h01;
          MODE_BOUNCE: begin
            leds_next = 8'h01;
            dir_next  = DIR_LEFT;
          end
          default:     leds_next = leds_reg;
        endcase
      end else begin
        if (mode_reg != MODE_HOLD)
          digit_next = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
        case (mode_reg)
          MODE_COUNT:  leds_next = leds_reg + 8'd1;
          MODE_CHASE:  leds_next = {leds_reg[6:0], leds_reg[7]};
          MODE_BOUNCE: begin
            if (!leds_onehot) begin
              leds_next = 8'h01;
              dir_next  = DIR_LEFT;
            end else if (dir_reg == DIR_LEFT) begin
              if (leds_reg == 8'h80) begin
                dir_next  = DIR_RIGHT;
                leds_next = 8'h40;
              end else begin
                leds_next = {leds_reg[6:0], 1'b0};
              end
            end else begin
              if (leds_reg == 8'h01) begin
                dir_next  = DIR_LEFT;
                leds_next = 8'h02;
              end else begin
                leds_next = {1'b0, leds_reg[7:1]};
              end
            end
          end
          default:     leds_next = leds_reg;
        endcase
      end
    end
  end

  always_comb begin
    case (digit_next)
      4'd0:    seg_next = 7'h3F;
      4'd1:    seg_next = 7'h06;
      4'd2:    seg_next = 7'h5B;
      4'd3:    seg_next = 7'h4F;
      4'd4:    seg_next = 7'h66;
      4'd5:    seg_next = 7'h6D;
      4'd6:    seg_next = 7'h7D;
      4'd7:    seg_next = 7'h07;
      4'd8:    seg_next = 7'h7F;
      4'd9:    seg_next = 7'h6F;
      default: seg_next = 7'h00;
    endcase
  end

  always_ff @(posedge i_clkPin or posedge i_rstPin) begin
    if (i_rstPin) begin
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      prev_reg  <= 1'b0;
      mode_reg  <= MODE_COUNT;
      dir_reg   <= DIR_LEFT;
      digit_reg <= 4'd0;
      leds_reg  <= 8'h00;
      seg_reg   <= 7'h3F;
      pulse_reg <= 1'b0;
    end else begin
      s1_reg    <= bus.i_slowClk;
      s2_reg    <= s1_reg;
      prev_reg  <= s2_reg;
      mode_reg  <= mode_next;
      dir_reg   <= dir_next;
      digit_reg <= digit_next;
      leds_reg  <= leds_next;
      seg_reg   <= seg_next;
      pulse_reg <= accept;
    end
  end

  assign bus.o_leds      = leds_reg;
  assign bus.o_seg       = seg_reg;
  assign bus.o_stepPulse = pulse_reg;
endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed test-plan sequences plus randomized slow-clock
// traffic, checked by a scoreboard fed from a position/direction reference model.
module tb_step_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  step_sequencer_if bus ();

  step_sequencer dut (
    .i_clkPin (clk),
    .i_rstPin (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] leds;
    logic [6:0] seg;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model: the bouncing light is a position 0..7 moving by +1/-1.
  int         m_mode;
  int         m_pos;
  int         m_dir;
  int         m_digit;
  logic [7:0] m_leds;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  default: return 7'h6F;
    endcase
  endfunction

  function automatic void model_reset();
    m_mode  = 0;
    m_pos   = 0;
    m_dir   = 1;
    m_digit = 0;
    m_leds  = 8'h00;
  endfunction

  // Called on the negedge at which the slow clock rises; the result is due 3 edges later.
  function automatic void model_step();
    exp_t e;
    int   md;
    if (!bus.i_ena) return;
    md = int'(bus.i_mode);
    if (md != m_mode) begin
      m_mode = md;
      if (md == 0) m_leds = 8'h00;
      else if (md == 1) m_leds = 8'h01;
      else if (md == 2) begin
        m_pos  = 0;
        m_dir  = 1;
        m_leds = 8'h01;
      end
    end else if (m_mode != 3) begin
      if (m_mode == 0) m_leds = m_leds + 8'd1;
      else if (m_mode == 1) m_leds = 8'((m_leds * 2) % 256 + m_leds / 128);
      else begin
        if (m_pos + m_dir > 7 || m_pos + m_dir < 0) m_dir = -m_dir;
        m_pos  = m_pos + m_dir;
        m_leds = 8'(1 << m_pos);
      end
      m_digit = (m_digit + 1) % 10;
    end
    e.leds = m_leds;
    e.seg  = seg_of(m_digit);
    e.cyc  = cyc + 3;
    sb.push_back(e);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic slow_step(input int h, input int l);
    bus.i_slowClk = 1'b1;
    model_step();
    repeat (h) @(negedge clk);
    bus.i_slowClk = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  // Monitor: every pulse pops one expectation; outputs must not move without a pulse.
  logic [7:0] last_leds;
  logic [6:0] last_seg;
  logic       last_pulse;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (rst) begin
      last_leds  = 8'h00;
      last_seg   = 7'h3F;
      last_pulse = 1'b0;
    end else begin
      if (bus.o_stepPulse) begin
        checks++;
        if (last_pulse) begin
          errors++;
          $display("FAIL pulse_double actual=1 required=0 cyc=%0d", cyc);
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual=1 required=0 cyc=%0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("sb_leds", bus.o_leds, mon_e.leds);
          check("sb_seg", {1'b0, bus.o_seg}, {1'b0, mon_e.seg});
          checks++;
          if (cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL sb_latency actual=%0d required=%0d", cyc, mon_e.cyc);
          end
        end
      end else if (bus.o_leds !== last_leds || bus.o_seg !== last_seg) begin
        checks++;
        errors++;
        $display("FAIL change_without_pulse actual=%h/%h required=%h/%h",
                 bus.o_leds, bus.o_seg, last_leds, last_seg);
      end
      last_leds  = bus.o_leds;
      last_seg   = bus.o_seg;
      last_pulse = bus.o_stepPulse;
    end
  end

  logic [7:0] bounce_exp [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};
  logic [6:0] saved_seg;

  initial begin
    bus.i_ena     = 1'b0;
    bus.i_mode    = 2'd0;
    bus.i_slowClk = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_leds", bus.o_leds, 8'h00);
    check("reset_seg", {1'b0, bus.o_seg}, 8'h3F);
    check("reset_pulse", {7'd0, bus.o_stepPulse}, 8'h00);
    rst = 1'b0;
    bus.i_ena = 1'b1;

    // First step with edge-by-edge latency check
    bus.i_slowClk = 1'b1;
    model_step();
    @(negedge clk); check("lat_e0_pulse", {7'd0, bus.o_stepPulse}, 8'h00);
    @(negedge clk); check("lat_e1_pulse", {7'd0, bus.o_stepPulse}, 8'h00);
                    check("lat_e1_leds", bus.o_leds, 8'h00);
    @(negedge clk); check("lat_e2_pulse", {7'd0, bus.o_stepPulse}, 8'h01);
                    check("lat_e2_leds", bus.o_leds, 8'h01);
                    check("count1_seg", {1'b0, bus.o_seg}, 8'h06);
    @(negedge clk); check("lat_e3_pulse", {7'd0, bus.o_stepPulse}, 8'h00);
    bus.i_slowClk = 1'b0;
    repeat (2) @(negedge clk);
    slow_step(2, 2);
    check("count2_leds", bus.o_leds, 8'h02);
    check("count2_seg", {1'b0, bus.o_seg}, 8'h5B);
    slow_step(2, 2);
    check("count3_leds", bus.o_leds, 8'h03);
    check("count3_seg", {1'b0, bus.o_seg}, 8'h4F);

    // Count wrap at the minimum slow period
    repeat (252) slow_step(2, 2);
    check("count255_leds", bus.o_leds, 8'hFF);
    check("count255_seg", {1'b0, bus.o_seg}, 8'h6D);
    slow_step(2, 2);
    check("count256_leds", bus.o_leds, 8'h00);
    check("count256_seg", {1'b0, bus.o_seg}, 8'h7D);

    // Mode switch into bounce
    bus.i_mode = 2'd2;
    slow_step(2, 2);
    check("bounce_load_leds", bus.o_leds, 8'h01);
    check("bounce_load_seg", {1'b0, bus.o_seg}, 8'h7D);
    for (int i = 0; i < 9; i++) begin
      slow_step(2, 3);
      check($sformatf("bounce%0d", i), bus.o_leds, bounce_exp[i]);
    end

    // Chaser wrap, then hold
    bus.i_mode = 2'd1;
    slow_step(3, 2);
    check("chase_load", bus.o_leds, 8'h01);
    repeat (7) slow_step(2, 2);
    check("chase_top", bus.o_leds, 8'h80);
    slow_step(2, 2);
    check("chase_wrap", bus.o_leds, 8'h01);
    saved_seg = bus.o_seg;
    bus.i_mode = 2'd3;
    slow_step(2, 2);
    check("hold_load", bus.o_leds, 8'h01);
    repeat (3) slow_step(2, 2);
    check("hold_leds", bus.o_leds, 8'h01);
    check("hold_seg", {1'b0, bus.o_seg}, {1'b0, saved_seg});

    // Enable gating
    bus.i_mode = 2'd0;
    slow_step(2, 2);
    check("gate_load", bus.o_leds, 8'h00);
    saved_seg = bus.o_seg;
    bus.i_ena = 1'b0;
    repeat (5) slow_step(2, 2);
    check("gate_leds", bus.o_leds, 8'h00);
    check("gate_seg", {1'b0, bus.o_seg}, {1'b0, saved_seg});
    bus.i_ena = 1'b1;
    slow_step(2, 2);
    check("gate_resume_leds", bus.o_leds, 8'h01);
    check("gate_resume_seg", {1'b0, bus.o_seg}, {1'b0, seg_of(m_digit)});

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) bus.i_mode = 2'($urandom_range(3));
      bus.i_ena = ($urandom_range(3) != 0);
      slow_step(int'($urandom_range(2, 5)), int'($urandom_range(2, 5)));
    end

    // Asynchronous reset mid-bounce, slow clock held high across release
    bus.i_ena  = 1'b1;
    bus.i_mode = 2'd2;
    repeat (3) slow_step(2, 2);
    bus.i_slowClk = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_leds", bus.o_leds, 8'h00);
    check("async_seg", {1'b0, bus.o_seg}, 8'h3F);
    check("async_pulse", {7'd0, bus.o_stepPulse}, 8'h00);
    sb.delete();
    model_reset();
    bus.i_mode = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_step();
    repeat (6) @(negedge clk);
    check("post_reset_leds", bus.o_leds, 8'h01);
    check("post_reset_seg", {1'b0, bus.o_seg}, 8'h06);
    bus.i_slowClk = 1'b0;
    repeat (4) @(negedge clk);

    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
